// File: rtl/uart_defs.sv
`default_nettype none
// ============================================================================
//  Module   : uart_defs (package)
//  Purpose  : Shared UART receiver definitions. Provides the baud-divisor
//             macros (`B9600, `B19200, `B57600, `B115200) for a 12 MHz
//             clock, matching localparams, and the receiver state encoding.
//  Revision : 1.0  initial release
// ============================================================================
`ifndef UART_DEFS_BAUD_MACROS
`define UART_DEFS_BAUD_MACROS
`define B9600   1250
`define B19200  625
`define B57600  208
`define B115200 104
`endif

package uart_defs;

  // Divisors for a 12 MHz system clock.
  localparam int unsigned c_b9600   = `B9600;
  localparam int unsigned c_b19200  = `B19200;
  localparam int unsigned c_b57600  = `B57600;
  localparam int unsigned c_b115200 = `B115200;

  // Receiver states. PARITY is only reachable when parity checking is built in.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  // Hack data words are 16 bits; characters are presented zero-extended.
  function automatic logic [15:0] zext_char(input logic [7:0] ch);
    return {8'h00, ch};
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo
//  Purpose  : First-word-fall-through FIFO, depth 2**AW. Pointers carry one
//             extra wrap bit so full/empty fall out of an MSB + address
//             compare. A push while full is dropped and flagged on ovf_o,
//             unless a pop happens in the same cycle.
//  Revision : 1.0  initial release
// ============================================================================
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [AW:0]      count_o,
  output logic             ovf_o
);

  localparam int unsigned c_depth = 2 ** AW;
  localparam logic [AW:0] c_ptr_one = (AW + 1)'(1);

  logic [WIDTH-1:0] mem_q [c_depth];
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic             w_empty, w_full, w_push, w_pop;

  assign w_empty = (wptr_q == rptr_q);
  assign w_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign w_pop   = rd_en_i && !w_empty;
  // When full, a simultaneous pop frees the head slot, which is exactly where
  // the write pointer lands, so the push can proceed.
  assign w_push  = wr_en_i && (!w_full || w_pop);

  assign rd_data_o = w_empty ? '0 : mem_q[rptr_q[AW-1:0]];
  assign empty_o   = w_empty;
  assign full_o    = w_full;
  assign count_o   = wptr_q - rptr_q;
  assign ovf_o     = wr_en_i && w_full && !w_pop;

  // Next pointer values.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (w_push) wptr_d = wptr_q + c_ptr_one;
    if (w_pop)  rptr_d = rptr_q + c_ptr_one;
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (w_push) mem_q[wptr_q[AW-1:0]] <= wr_data_i;
  end

endmodule

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_fifo
//  Purpose  : Oversampling serial receiver (5..8 data bits, LSB first) with a
//             FWFT character FIFO, sticky framing and overrun flags. Output
//             words are zero-extended to 16 bits for the Hack I/O map.
//  Config   : `define UART_RX_PARITY_EN adds one parity bit before stop
//             (even, or odd when PARITY_ODD=1). Without it no parity logic
//             exists and PARITY_ODD is ignored.
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx_fifo
  import uart_defs::*;
#(
  parameter int unsigned BAUD_DIV   = 104,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_AW    = 4,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               rx,
  input  logic               rd_en,
  input  logic               err_clr,
  output logic [15:0]        rd_data,
  output logic               empty,
  output logic               full,
  output logic [FIFO_AW:0]   count,
  output logic               busy,
  output logic               frame_err,
  output logic               overrun
);

  localparam int unsigned        c_cnt_w  = $clog2(BAUD_DIV);
  localparam logic [c_cnt_w-1:0] c_half   = c_cnt_w'(BAUD_DIV / 2);
  // Reloading with BAUD_DIV-1 makes consecutive samples exactly BAUD_DIV ticks apart.
  localparam logic [c_cnt_w-1:0] c_full   = c_cnt_w'(BAUD_DIV - 1);
  localparam logic [c_cnt_w-1:0] c_one    = c_cnt_w'(1);
  localparam logic [2:0]         c_last   = 3'(DATA_BITS - 1);

  rx_state_e              state_q, state_d;
  logic [c_cnt_w-1:0]     cnt_q, cnt_d;
  logic [2:0]             bitcnt_q, bitcnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   rx_s1_q, rx_s2_q, rx_prev_q;
  logic                   frame_err_q, overrun_q;
  logic                   w_tick, w_push, w_frame_evt, w_par_bad, w_ovf;
  logic [7:0]             w_char, w_fifo_rd;

`ifdef UART_RX_PARITY_EN
  logic par_err_q, par_err_d;
  assign w_par_bad = par_err_q;
`else
  logic w_unused_par_odd;
  assign w_unused_par_odd = (PARITY_ODD != 0);
  assign w_par_bad        = 1'b0;
`endif

  assign w_tick = (cnt_q == '0);

  // Two-flop synchroniser plus one delayed copy for start-edge detection.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  // Receiver state, bit timer, bit counter and shift register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bitcnt_q  <= '0;
      shift_q   <= '0;
`ifdef UART_RX_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bitcnt_q  <= bitcnt_d;
      shift_q   <= shift_d;
`ifdef UART_RX_PARITY_EN
      par_err_q <= par_err_d;
`endif
    end
  end

  // Frame sequencing: mid-bit sampling, stop-bit verdict and FIFO push.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bitcnt_d    = bitcnt_q;
    shift_d     = shift_q;
    w_push      = 1'b0;
    w_frame_evt = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_d   = par_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (rx_prev_q && !rx_s2_q) begin
          state_d = START;
          cnt_d   = c_half;
        end
      end
      START: begin
        if (w_tick) begin
          if (!rx_s2_q) begin
            state_d  = DATA;
            cnt_d    = c_full;
            bitcnt_d = '0;
          end else begin
            // Line went high again before mid-start: a glitch, not a frame.
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - c_one;
        end
      end
      DATA: begin
        if (w_tick) begin
          shift_d = {rx_s2_q, shift_q[DATA_BITS-1:1]};
          cnt_d   = c_full;
          if (bitcnt_q == c_last) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bitcnt_d = bitcnt_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - c_one;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (w_tick) begin
          par_err_d = rx_s2_q ^ (^shift_q) ^ (PARITY_ODD != 0);
          state_d   = STOP;
          cnt_d     = c_full;
        end else begin
          cnt_d = cnt_q - c_one;
        end
      end
`endif
      STOP: begin
        if (w_tick) begin
          // Leave half a bit early so a back-to-back start edge is not missed.
          state_d = IDLE;
          if (rx_s2_q && !w_par_bad) w_push      = 1'b1;
          else                       w_frame_evt = 1'b1;
        end else begin
          cnt_d = cnt_q - c_one;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sticky error flags; a new event beats a simultaneous clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (w_frame_evt)  frame_err_q <= 1'b1;
      else if (err_clr) frame_err_q <= 1'b0;
      if (w_ovf)        overrun_q   <= 1'b1;
      else if (err_clr) overrun_q   <= 1'b0;
    end
  end

  // Received bits zero-extended to the FIFO's byte width.
  always_comb begin
    w_char                = '0;
    w_char[DATA_BITS-1:0] = shift_q;
  end

  sync_fifo #(
    .WIDTH (8),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .wr_en_i   (w_push),
    .wr_data_i (w_char),
    .rd_en_i   (rd_en),
    .rd_data_o (w_fifo_rd),
    .empty_o   (empty),
    .full_o    (full),
    .count_o   (count),
    .ovf_o     (w_ovf)
  );

  assign rd_data   = zext_char(w_fifo_rd);
  assign busy      = (state_q != IDLE);
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_fifo
//  Purpose  : Self-checking bench for uart_rx_fifo at 115200 baud with a
//             four-entry FIFO. Expected characters are queued as frames are
//             sent and compared when read back.
//  Revision : 1.0  initial release
// ============================================================================
`ifndef B115200
`define B115200 104
`endif

module tb_uart_rx_fifo;

  localparam int c_baud  = `B115200;
  localparam int c_aw    = 2;
  localparam int c_depth = 4;
`ifdef UART_RX_PARITY_EN
  localparam int c_frame_bits = 11;
`else
  localparam int c_frame_bits = 10;
`endif

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              rx = 1'b1;
  logic              rd_en = 1'b0;
  logic              err_clr = 1'b0;
  logic [15:0]       rd_data;
  logic              empty, full, busy, frame_err, overrun;
  logic [c_aw:0]     count;

  int                n_chk = 0;
  int                n_pass = 0;
  int                push_edge = 0;
  logic [15:0]       exp_q[$];

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .BAUD_DIV   (c_baud),
    .DATA_BITS  (8),
    .FIFO_AW    (c_aw),
    .PARITY_ODD (0)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .rx        (rx),
    .rd_en     (rd_en),
    .err_clr   (err_clr),
    .rd_data   (rd_data),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Drive one frame; each bit lasts c_baud clocks, changes on falling edges.
  task automatic send_car(input logic [7:0] c, input logic stop_bit, input logic par_flip);
    @(negedge clk); rx = 1'b0;
    repeat (c_baud - 1) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); rx = c[i];
      repeat (c_baud - 1) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    @(negedge clk); rx = (^c) ^ par_flip;
    repeat (c_baud - 1) @(negedge clk);
`endif
    @(negedge clk); rx = stop_bit;
    repeat (c_baud - 1) @(negedge clk);
    @(negedge clk); rx = 1'b1;
  endtask

  // Send a frame and record what the FIFO should end up holding.
  task automatic send_exp(input logic [7:0] c, input logic stop_bit, input logic par_flip);
    send_car(c, stop_bit, par_flip);
    if (stop_bit && !par_flip && exp_q.size() < c_depth) exp_q.push_back({8'h00, c});
  endtask

  // Compare the FIFO head with the scoreboard, then pop it.
  task automatic pop_chk(input string tag);
    logic [15:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'h0000;
    check({tag, "_empty"}, empty, 1'b0);
    check({tag, "_data"}, rd_data, e);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  // Raise rd_en only for the cycle in which the frame's character is pushed.
  task automatic pulse_at_push(input string tag);
    @(negedge clk);
    repeat (push_edge - 1) @(posedge clk);
    @(negedge clk);
    check({tag, "_head"}, rd_data, exp_q[0]);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic clear_errors();
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
  endtask

  initial begin
    #800_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    bit prev_empty;
    int n;

    // ---------------- reset values ----------------
    repeat (3) @(negedge clk);
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    check("rst_count", count, 0);
    check("rst_rd_data", rd_data, 16'h0000);
    check("rst_busy", busy, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    rstn = 1'b1;
    repeat (4) @(negedge clk);

    // ---------------- single character, latency ----------------
    fork
      send_exp(8'h31, 1'b1, 1'b0);
      begin
        n = 0; seen = 0; prev_empty = 1'b1;
        @(negedge clk);
        while (n < c_frame_bits * c_baud + 50) begin
          @(posedge clk); n++;
          @(negedge clk);
          if (busy) seen = 1;
          else if (seen) break;
          prev_empty = empty;
        end
        push_edge = n;
        check("t1_busy_seen", seen, 1'b1);
        check("t1_empty_before_push", prev_empty, 1'b1);
        check("t1_empty_after_push", empty, 1'b0);
        check("t1_push_in_stop_bit",
              (n >= (c_frame_bits - 1) * c_baud) && (n < c_frame_bits * c_baud), 1'b1);
      end
    join
    pop_chk("t1_pop");
    check("t1_empty_after_pop", empty, 1'b1);
    check("t1_data_after_pop", rd_data, 16'h0000);

    // ---------------- 0.3-bit glitch ----------------
    seen = 0;
    @(negedge clk); rx = 1'b0;
    for (int i = 0; i < (c_baud * 3) / 10; i++) begin
      @(negedge clk);
      if (busy) seen = 1;
    end
    rx = 1'b1;
    for (int i = 0; i < 2 * c_baud && busy; i++) @(negedge clk);
    check("t2_busy_pulsed", seen, 1'b1);
    check("t2_busy_clear", busy, 1'b0);
    check("t2_empty", empty, 1'b1);
    check("t2_frame_err", frame_err, 1'b0);

    // ---------------- fill past full ----------------
    send_exp(8'h31, 1'b1, 1'b0);
    send_exp(8'h30, 1'b1, 1'b0);
    send_exp(8'h31, 1'b1, 1'b0);
    send_exp(8'h0A, 1'b1, 1'b0);
    send_exp(8'h0A, 1'b1, 1'b0);
    check("t3_full", full, 1'b1);
    check("t3_count", count, c_depth);
    check("t3_overrun", overrun, 1'b1);
    check("t3_head", rd_data, 16'h0031);
    check("t3_frame_err", frame_err, 1'b0);

    // ---------------- stream at full with coincident pops ----------------
    clear_errors();
    check("t5_overrun_cleared", overrun, 1'b0);
    for (int k = 0; k < 2; k++) begin
      logic [7:0] c;
      c = 8'h41 + 8'(k);
      fork
        send_car(c, 1'b1, 1'b0);
        pulse_at_push("t5");
      join
      void'(exp_q.pop_front());
      exp_q.push_back({8'h00, c});
      check("t5_count", count, c_depth);
      check("t5_full", full, 1'b1);
      check("t5_no_overrun", overrun, 1'b0);
    end
    for (int k = 0; k < c_depth; k++) pop_chk("t5_drain");
    check("t5_empty", empty, 1'b1);

    // ---------------- bad stop bit, clear racing the error ----------------
    fork
      send_car(8'h55, 1'b0, 1'b0);
      begin
        @(negedge clk);
        repeat (push_edge - 1) @(posedge clk);
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
      end
    join
    check("t4_not_pushed", empty, 1'b1);
    check("t4_frame_err_set_wins", frame_err, 1'b1);
    repeat (c_baud) @(negedge clk);
    check("t4_idle_after", busy, 1'b0);
    clear_errors();
    check("t4_frame_err_cleared", frame_err, 1'b0);

`ifdef UART_RX_PARITY_EN
    // ---------------- parity mismatch ----------------
    send_exp(8'h31, 1'b1, 1'b1);
    check("t6_par_frame_err", frame_err, 1'b1);
    check("t6_par_not_pushed", empty, 1'b1);
    clear_errors();
    send_exp(8'h31, 1'b1, 1'b0);
    check("t6_par_ok_no_err", frame_err, 1'b0);
    pop_chk("t6_pop");
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
